// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC and assembles each 32-bit instruction from
// four in-order byte reads on the shared memory port. A redirect discards the
// word in flight and drains its outstanding responses before refetching.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy_i,
    input  logic [4:0]  stall_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_addr_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [7:0]  mem_rdata_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        stall_req_o
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_DONE  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic [2:0]  issued_q, issued_d;
    logic [2:0]  recvd_q, recvd_d;
    logic [2:0]  pend_q, pend_d;

    logic [2:0]  outst;       // responses still owed to us this cycle
    logic        rv_ok;       // response that matches an outstanding request
    logic        gnt_fire;    // request accepted this cycle
    logic [2:0]  redir_out;   // responses left in flight after a redirect

    // Only stall[1] (IF/ID capture) matters to this stage.
    logic unused_stall;
    assign unused_stall = ^{stall_i[4:2], stall_i[0]};

    assign mem_req_o   = rdy_i & ~rst & (state_q == S_FETCH) & (issued_q < 3'd4);
    assign mem_addr_o  = pc_q + {29'd0, issued_q};
    assign if_pc_o     = pc_q;
    assign if_inst_o   = buf_q;
    assign stall_req_o = (state_q != S_DONE);

    assign gnt_fire = mem_req_o & mem_gnt_i;

    // Outstanding count per state; a stray rvalid with nothing owed is ignored.
    always_comb begin
        outst = 3'd0;
        case (state_q)
            S_FETCH: outst = issued_q - recvd_q;
            S_DRAIN: outst = pend_q;
            default: outst = 3'd0;
        endcase
        rv_ok     = mem_rvalid_i & (outst != 3'd0);
        redir_out = outst - {2'd0, rv_ok} + {2'd0, gnt_fire};
    end

    // Next-state logic; a redirect overrides every state's normal behaviour.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        buf_d    = buf_q;
        issued_d = issued_q;
        recvd_d  = recvd_q;
        pend_d   = pend_q;
        if (br_taken_i) begin
            pc_d     = br_addr_i;
            issued_d = 3'd0;
            recvd_d  = 3'd0;
            if (redir_out != 3'd0) begin
                pend_d  = redir_out;
                state_d = S_DRAIN;
            end else begin
                pend_d  = 3'd0;
                state_d = S_FETCH;
            end
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (gnt_fire) issued_d = issued_q + 3'd1;
                    if (rv_ok) begin
                        buf_d[{recvd_q[1:0], 3'b000} +: 8] = mem_rdata_i;
                        recvd_d = recvd_q + 3'd1;
                        if (recvd_q == 3'd3) state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (!stall_i[1]) begin
                        pc_d     = pc_q + 32'd4;
                        issued_d = 3'd0;
                        recvd_d  = 3'd0;
                        state_d  = S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (rv_ok) pend_d = pend_q - 3'd1;
                    if (pend_q == 3'd0 || (rv_ok && pend_q == 3'd1)) begin
                        pend_d   = 3'd0;
                        issued_d = 3'd0;
                        recvd_d  = 3'd0;
                        state_d  = S_FETCH;
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    // State registers; rdy low freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            buf_q    <= 32'd0;
            issued_q <= 3'd0;
            recvd_q  <= 3'd0;
            pend_q   <= 3'd0;
        end else if (rdy_i) begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            buf_q    <= buf_d;
            issued_q <= issued_d;
            recvd_q  <= recvd_d;
            pend_q   <= pend_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: a directed vector table for the first fetch, hand
// sequences for stall/grant/redirect/rdy/wrap corners, and a randomized run
// against a memory-controller model and an expected-PC tracker.
module tb_inst_fetch;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rdy, br_taken, mem_gnt, mem_rvalid;
    logic [4:0]  stall;
    logic [31:0] br_addr;
    logic [7:0]  mem_rdata;
    logic        mem_req, stall_req;
    logic [31:0] mem_addr, if_pc, if_inst;

    inst_fetch #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .rdy_i(rdy), .stall_i(stall),
        .br_taken_i(br_taken), .br_addr_i(br_addr),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_gnt_i(mem_gnt),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .if_pc_o(if_pc), .if_inst_o(if_inst), .stall_req_o(stall_req)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          gen;
    } rsp_t;
    rsp_t q[$];

    int          cyc, gen, gcnt, idle;
    logic [31:0] exp_pc;
    logic        k_rdy, k_gnt, k_st1, k_br;
    logic [31:0] k_braddr;
    int          k_lat;
    logic        s_req, s_sreq;
    logic [31:0] s_addr, s_pc, s_inst;

    function automatic logic [7:0] mbyte(input logic [31:0] a);
        logic [7:0] h;
        case (a)
            32'd0:   h = 8'h13;
            32'd1:   h = 8'h05;
            32'd2:   h = 8'h10;
            32'd3:   h = 8'h00;
            default: h = (a[7:0] * 8'd29) ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
        endcase
        return h;
    endfunction

    function automatic logic [31:0] mword(input logic [31:0] p);
        return {mbyte(p + 32'd3), mbyte(p + 32'd2), mbyte(p + 32'd1), mbyte(p)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; rdy = 1'b1; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        br_taken = 1'b0; br_addr = 32'd0; stall = 5'd0; mem_rdata = 8'd0;
        q.delete();
        @(negedge clk);
        chk("req_in_rst", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_pc", if_pc, RPC);
        chk("rst_inst", if_inst, 32'd0);
        chk("rst_stall_req", 32'(stall_req), 32'd1);
        chk("rst_req", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_pc = RPC; gcnt = 0; gen++; cyc = 0; idle = 0;
        k_rdy = 1'b1; k_gnt = 1'b1; k_st1 = 1'b0; k_br = 1'b0;
        k_braddr = 32'd0; k_lat = 2;
    endtask

    // One clock: memory controller model drives responses, outputs are
    // checked against the expected-PC tracker, then the model advances.
    task automatic cycle();
        logic rv;
        int   st;
        rdy = k_rdy; mem_gnt = k_gnt; stall = {3'b000, k_st1, 1'b0};
        br_taken = k_br; br_addr = k_braddr;
        rv = k_rdy && (q.size() > 0) && (q[0].due <= cyc);
        mem_rvalid = rv;
        mem_rdata  = rv ? mbyte(q[0].addr) : 8'($urandom);
        @(negedge clk);
        s_req = mem_req; s_addr = mem_addr; s_sreq = stall_req;
        s_pc = if_pc; s_inst = if_inst;
        if (!k_rdy) chk("req_rdy_low", 32'(mem_req), 32'd0);
        if (!stall_req) begin
            chk("word_pc", if_pc, exp_pc);
            chk("word_inst", if_inst, mword(exp_pc));
            chk("req_in_done", 32'(mem_req), 32'd0);
        end
        if (mem_req) begin
            st = 0;
            foreach (q[i]) if (q[i].gen != gen) st++;
            chk("req_addr", mem_addr, exp_pc + gcnt);
            chk("req_while_draining", 32'(st), 32'd0);
            chk("req_count", 32'(gcnt < 4), 32'd1);
        end
        if (k_rdy) begin
            if (mem_req && mem_gnt) begin
                q.push_back('{exp_pc + gcnt, cyc + k_lat, gen});
                gcnt++;
            end
            if (rv) void'(q.pop_front());
            if (stall_req) idle++; else idle = 0;
            if (k_br) begin
                exp_pc = k_braddr; gcnt = 0; gen++; idle = 0;
            end else if (!stall_req && !k_st1) begin
                exp_pc = exp_pc + 32'd4; gcnt = 0;
            end
            if (idle > 80) begin
                chk("fetch_progress", 32'(idle), 32'd0);
                idle = 0;
            end
        end
        cyc++;
        @(posedge clk); #1;
    endtask

    task automatic run_until_done(input string nm);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (s_sreq && n < 60);
        chk(nm, 32'(s_sreq), 32'd0);
    endtask

    typedef struct {
        logic        gnt, rv;
        logic [7:0]  rd;
        logic        st1, exp_req;
        logic [31:0] exp_addr;
        logic        exp_sreq;
        logic [31:0] exp_pc, exp_inst;
    } vec_t;
    vec_t vt[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc0, inst0;
        int          n;
        gen = 0;
        // First fetch from reset: grant every cycle, 2-cycle return.
        vt[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 32'd0, 1'b1, 32'd0, 32'd0};
        vt[1] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 32'd1, 1'b1, 32'd0, 32'd0};
        vt[2] = '{1'b1, 1'b1, 8'h13, 1'b0, 1'b1, 32'd2, 1'b1, 32'd0, 32'd0};
        vt[3] = '{1'b1, 1'b1, 8'h05, 1'b0, 1'b1, 32'd3, 1'b1, 32'd0, 32'd0};
        vt[4] = '{1'b1, 1'b1, 8'h10, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0, 32'd0};
        vt[5] = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0, 32'd0};
        vt[6] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'h0010_0513};
        vt[7] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'd4, 1'b1, 32'd4, 32'd0};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            rdy = 1'b1; br_taken = 1'b0;
            mem_gnt = vt[i].gnt; mem_rvalid = vt[i].rv; mem_rdata = vt[i].rd;
            stall = {3'b000, vt[i].st1, 1'b0};
            @(negedge clk);
            chk($sformatf("vec%0d_req", i), 32'(mem_req), 32'(vt[i].exp_req));
            if (vt[i].exp_req) chk($sformatf("vec%0d_addr", i), mem_addr, vt[i].exp_addr);
            chk($sformatf("vec%0d_stall_req", i), 32'(stall_req), 32'(vt[i].exp_sreq));
            chk($sformatf("vec%0d_pc", i), if_pc, vt[i].exp_pc);
            if (!vt[i].exp_sreq) chk($sformatf("vec%0d_inst", i), if_inst, vt[i].exp_inst);
            @(posedge clk); #1;
        end

        // Downstream stall holds the word for 5 cycles.
        do_reset();
        k_st1 = 1'b1;
        run_until_done("stall_fetch_done");
        pc0 = s_pc; inst0 = s_inst;
        repeat (4) begin
            cycle();
            chk("stall_pc_hold", s_pc, pc0);
            chk("stall_inst_hold", s_inst, inst0);
            chk("stall_no_req", 32'(s_req), 32'd0);
        end
        k_st1 = 1'b0;
        cycle();
        cycle();
        chk("stall_release_pc", s_pc, 32'd4);
        chk("stall_release_addr", s_addr, 32'd4);

        // Grant withheld on the second byte.
        do_reset();
        cycle();
        k_gnt = 1'b0;
        repeat (3) begin
            cycle();
            chk("nogrant_req", 32'(s_req), 32'd1);
            chk("nogrant_addr", s_addr, 32'd1);
        end
        k_gnt = 1'b1; k_st1 = 1'b1;
        run_until_done("nogrant_done");
        chk("nogrant_inst", s_inst, 32'h0010_0513);

        // Redirect with 3 issued, 1 returned: two stale bytes to drain.
        do_reset();
        k_lat = 1; cycle();
        k_lat = 5; cycle(); cycle();
        k_gnt = 1'b0; k_br = 1'b1; k_braddr = 32'h100;
        cycle();
        k_br = 1'b0; k_gnt = 1'b1; k_lat = 2;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!s_req && n < 20);
        chk("drain_len", 32'(n), 32'd5);
        chk("drain_refetch_addr", s_addr, 32'h100);
        k_st1 = 1'b1;
        run_until_done("redir_done");
        chk("redir_inst", s_inst, mword(32'h100));

        // Redirect together with the 4th response: no DONE, refetch at once.
        do_reset();
        repeat (5) cycle();
        k_br = 1'b1; k_braddr = 32'h200;
        cycle();
        k_br = 1'b0;
        cycle();
        chk("simul_no_done", 32'(s_sreq), 32'd1);
        chk("simul_req", 32'(s_req), 32'd1);
        chk("simul_addr", s_addr, 32'h200);
        // Redirect while in DONE with stall[1]=0 beats pc+4.
        k_st1 = 1'b1;
        run_until_done("simul_done");
        k_st1 = 1'b0; k_br = 1'b1; k_braddr = 32'h300;
        cycle();
        k_br = 1'b0;
        cycle();
        chk("done_redir_pc", s_pc, 32'h300);
        chk("done_redir_addr", s_addr, 32'h300);

        // rdy low mid-fetch freezes everything.
        do_reset();
        repeat (3) cycle();
        k_rdy = 1'b0;
        repeat (4) begin
            cycle();
            chk("rdy_low_req", 32'(s_req), 32'd0);
            chk("rdy_low_stall_req", 32'(s_sreq), 32'd1);
            chk("rdy_low_pc", s_pc, 32'd0);
        end
        k_rdy = 1'b1;
        cycle();
        chk("rdy_resume_addr", s_addr, 32'd3);
        k_st1 = 1'b1;
        run_until_done("rdy_done");
        chk("rdy_inst", s_inst, 32'h0010_0513);

        // Address wrap at the top of memory.
        do_reset();
        k_gnt = 1'b0; k_br = 1'b1; k_braddr = 32'hFFFF_FFFC;
        cycle();
        k_br = 1'b0; k_gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk($sformatf("wrap_addr%0d", i), s_addr, 32'hFFFF_FFFC + 32'(i));
        end
        run_until_done("wrap_done");
        cycle();
        chk("wrap_pc", s_pc, 32'd0);
        chk("wrap_next_addr", s_addr, 32'd0);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            k_rdy    = ($urandom_range(0, 9) != 0);
            k_gnt    = ($urandom_range(0, 9) < 7);
            k_lat    = int'($urandom_range(1, 4));
            k_st1    = ($urandom_range(0, 9) < 3);
            k_br     = ($urandom_range(0, 39) == 0);
            k_braddr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC
                                                   : {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage of the RISC-V core. It owns the program counter and fetches each 32-bit instruction as four byte reads over the shared byte-wide memory port, with an in-order, pipelined request/grant/response handshake. It presents `if_pc`/`if_inst` to the IF/ID pipeline register and raises `stall_req` until the word is complete. Branch and jump redirects from ID discard the fetch in flight and drain its outstanding responses before refetching.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `rdy` input 1: global enable; when low, all state is frozen and `mem_req`=0.
- `stall` input 5: pipeline stall vector. `stall[1]`=1 means IF/ID will not capture this cycle.
- `br_taken` input 1: redirect (ID `use_npc`, qualified by ctrl).
- `br_addr` input 32: redirect target.
- `mem_req` output 1: byte read request.
- `mem_addr` output 32: byte address of the request.
- `mem_gnt` input 1: arbiter accepts the request this cycle.
- `mem_rvalid` input 1: read byte returns this cycle. Returns are in order, at least 1 cycle after grant.
- `mem_rdata` input 8: returned byte.
- `if_pc` output 32: PC of the word in `if_inst`.
- `if_inst` output 32: assembled instruction; valid only when `stall_req`=0.
- `stall_req` output 1: fetch not complete; ctrl uses it to raise `stall[0]`.

## Operation
- State registers:
  - `pc`: 32 bits.
  - `buf`: 32 bits.
  - `issued`: 3 bits, 0..4.
  - `recvd`: 3 bits, 0..4.
  - `pend`: 3 bits, outstanding responses to discard.
  - FSM `state`: FETCH, DONE or DRAIN.
- Output mapping: `if_pc`=`pc`, `if_inst`=`buf`, `stall_req` = (state≠DONE).
- `mem_req` = rdy & !rst & state==FETCH & issued<4. `mem_addr` = pc + issued.
- Byte order is little-endian: the k-th response is written to `buf[8k+7:8k]`.
- FETCH:
  - A cycle with `mem_req`&`mem_gnt` increments `issued`.
  - A cycle with `mem_rvalid` writes `buf` and increments `recvd`.
  - When the response with recvd==3 arrives, go to DONE next cycle.
- DONE:
  - Hold `pc` and `buf`.
  - If stall[1]=0: pc←pc+4, clear `issued` and `recvd`, go to FETCH.
  - If stall[1]=1: stay in DONE.
- DRAIN:
  - `mem_req`=0.
  - Each `mem_rvalid` decrements `pend`; the data is discarded.
  - When `pend` reaches 0, including via the decrement this cycle, go to FETCH with counters cleared.
- Redirect (`br_taken`=1 & rdy):
  - Applies in any state and has priority over everything else.
  - pc←br_addr; `issued` and `recvd` are cleared.
  - Outstanding count o = issued − recvd − (mem_rvalid?1:0) + (mem_req&mem_gnt?1:0). In DRAIN, o = pend − mem_rvalid.
  - If o>0: pend←o, go to DRAIN. Otherwise go to FETCH.
  - `buf` is not cleared; IF/ID discards it via bj_stall.
- `mem_rvalid` with nothing outstanding is a protocol error and is ignored. The bench asserts it never occurs.
- Address arithmetic wraps modulo 2^32: pc=FFFF_FFFC yields byte addresses FFFF_FFFC..FFFF_FFFF, then next pc=0.

## Timing
- Reset values:
  - pc=RESET_PC, buf=0, state=FETCH, counters=0.
  - Outputs: if_pc=RESET_PC, if_inst=0, stall_req=1, mem_req=0 during the rst cycle.
  - Reset mid-fetch abandons all outstanding responses. The memory controller is reset in the same cycle.
- With grant every cycle and 2-cycle return:
  - Requests issue on cycles 1–4 after reset release.
  - Responses arrive on cycles 3–6.
  - stall_req falls on cycle 7.
  - Back-to-back throughput is one instruction per 7 cycles.
- `mem_addr` holds stable while `mem_req`=1 and `mem_gnt`=0.
- When rdy=0, nothing changes. A `mem_rvalid` during rdy=0 is not permitted; the controller is also gated by rdy.
- Redirect in the same cycle as the final response: the redirect wins, the byte is not written, and o excludes it.
- Redirect while in DONE with stall[1]=0: the redirect wins and pc←br_addr, not pc+4.

## Test plan
- **Reset fetch:** reset, RESET_PC=0, memory bytes 13 05 10 00 at 0..3, gnt=1, latency 2 → mem_addr sequence 0,1,2,3; stall_req=0 on cycle 7 with if_inst=0x00100513, if_pc=0; next cycle mem_addr=4.
- **Downstream stall:** word complete, stall[1]=1 for 5 cycles → if_pc/if_inst stable and mem_req=0; on release, pc=4 the following cycle.
- **Grant withheld:** mem_gnt=0 for 3 cycles on the 2nd byte → mem_addr=1 held with mem_req=1; the instruction still assembles correctly.
- **Redirect mid-fetch:** 3 bytes issued, 1 returned, br_taken with br_addr=0x100 → state DRAIN, pend=2, mem_req=0 until both stale bytes return; then mem_addr=0x100 and the new word contains no stale bytes.
- **Simultaneous events:** br_taken on the same cycle as the 4th response → no DONE; fetch restarts at br_addr immediately (pend=0). Separately, redirect while in DONE with stall[1]=0 → pc=br_addr.
- **rdy low and wrap:** rdy=0 for 4 cycles mid-fetch → no state change and mem_req=0. Separately, pc=0xFFFF_FFFC → addresses FFFF_FFFC..FFFF_FFFF, then pc=0.
